// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer.
package pc_seq_pkg;

  localparam int PC_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_incr.sv
// Combinational PC_W-bit plus-one with carry-out.
module pc_incr
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] a,
  output logic [PC_W-1:0] sum,
  output logic            co
);

  assign {co, sum} = {1'b0, a} + {{PC_W{1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with valid/ready fetch handshake and pending branch.
// Optional feature macro: PC_WRAP_HALT_EN (increment carry-out halts instead of wrapping).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic            ovf,
  output logic            halted
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  pc_state_e       state, nstate;
  logic [PC_W-1:0] pc_q, pend_pc, inc_pc, nxt_pc;
  logic            pend_v, ovf_q, inc_co;
  logic            xfer, use_inc, wrap, wrap_halt;

  pc_incr #(.PC_W(PC_W)) u_incr (
    .a   (pc_q),
    .sum (inc_pc),
    .co  (inc_co)
  );

  // A same-cycle branch beats a held one; only the increment path can carry.
  always_comb begin
    xfer    = pc_valid & pc_ready;
    use_inc = ~br_valid & ~pend_v;
    nxt_pc  = br_valid ? br_target : (pend_v ? pend_pc : inc_pc);
    wrap    = xfer & use_inc & inc_co;
`ifdef PC_WRAP_HALT_EN
    wrap_halt = wrap;
`else
    wrap_halt = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (en) nstate = RUN;
      RUN: begin
        // Leaving RUN only ever happens on a transfer so pc_valid never drops early.
        if (xfer) begin
          if (wrap_halt)  nstate = HALT;
          else if (!en)   nstate = IDLE;
          else if (stall) nstate = STALL;
        end
      end
      STALL: begin
        if (!en)         nstate = IDLE;
        else if (!stall) nstate = RUN;
      end
      HALT:    nstate = HALT;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    pc_valid = (state == RUN);
    halted   = (state == HALT);
    pc       = pc_q;
    ovf      = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RST_PC;
      ovf_q   <= 1'b0;
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      if (xfer && !wrap_halt) pc_q <= nxt_pc;
      if (wrap)               ovf_q <= 1'b1;
      if (xfer) begin
        pend_v <= 1'b0;
      end else if (br_valid && state != HALT) begin
        pend_v  <= 1'b1;
        pend_pc <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (PC_W=2, RESET_PC=0); honours PC_WRAP_HALT_EN.
module tb_pc_sequencer;

  localparam int PC_W = 2;

  logic            clk = 1'b0;
  logic            rst_n, en, stall, br_valid, pc_ready;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc;
  logic            pc_valid, ovf, halted;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .ovf       (ovf),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk("q_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0; pc_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Every offered PC that is accepted must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && pc_valid && pc_ready) begin
      if (exp_q.size() == 0) chk("xfer_extra", 32'(exp_q.size()), 32'd1);
      else                   chk("xfer_pc", 32'(pc), exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0; pc_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(pc_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Count through the whole range and across all-ones.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    en = 1'b1; pc_ready = 1'b1;
    tick();
    chk("run_valid", 32'(pc_valid), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    pc_ready = 1'b0;
    chk("wrap_ovf", 32'(ovf), 32'd1);
`ifdef PC_WRAP_HALT_EN
    chk("wrap_pc", 32'(pc), 32'd3);
    chk("wrap_halted", 32'(halted), 32'd1);
    chk("wrap_valid", 32'(pc_valid), 32'd0);
    br_valid = 1'b1; br_target = 2'd1; pc_ready = 1'b1;
    tick(); tick();
    br_valid = 1'b0; pc_ready = 1'b0;
    chk("halt_hold_pc", 32'(pc), 32'd3);
    chk("halt_hold", 32'(halted), 32'd1);
`else
    chk("wrap_pc", 32'(pc), 32'd0);
    chk("wrap_halted", 32'(halted), 32'd0);
    chk("wrap_valid", 32'(pc_valid), 32'd1);
`endif

    // Back-pressure holds pc and pc_valid.
    do_reset();
    en = 1'b1; pc_ready = 1'b1;
    exp_q.push_back(32'd0);
    tick(); tick();
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", 32'(pc), 32'd1);
      chk("bp_valid", 32'(pc_valid), 32'd1);
    end
    exp_q.push_back(32'd1);
    pc_ready = 1'b1;
    tick();
    pc_ready = 1'b0;
    chk("bp_release_pc", 32'(pc), 32'd2);

    // Branches during STALL: latest wins and the entry is used once.
    do_reset();
    en = 1'b1; pc_ready = 1'b1; stall = 1'b1;
    exp_q.push_back(32'd0);
    tick(); tick();
    chk("stall_valid", 32'(pc_valid), 32'd0);
    chk("stall_pc", 32'(pc), 32'd1);
    br_valid = 1'b1; br_target = 2'd3;
    tick();
    br_target = 2'd0;
    tick();
    br_valid = 1'b0; stall = 1'b0;
    tick();
    chk("resume_valid", 32'(pc_valid), 32'd1);
    exp_q.push_back(32'd1);
    tick();
    chk("pend_pc", 32'(pc), 32'd0);
    exp_q.push_back(32'd0);
    tick();
    pc_ready = 1'b0;
    chk("pend_cleared_pc", 32'(pc), 32'd1);
    chk("pend_ovf", 32'(ovf), 32'd0);

    // Same-cycle branches, including from all-ones, never touch ovf.
    do_reset();
    en = 1'b1; pc_ready = 1'b1;
    exp_q.push_back(32'd0);
    tick(); tick();
    exp_q.push_back(32'd1);
    br_valid = 1'b1; br_target = 2'd0;
    tick();
    chk("br_pc", 32'(pc), 32'd0);
    chk("br_ovf", 32'(ovf), 32'd0);
    exp_q.push_back(32'd0);
    br_target = 2'd3;
    tick();
    exp_q.push_back(32'd3);
    br_target = 2'd1;
    tick();
    br_valid = 1'b0; pc_ready = 1'b0;
    chk("br_ones_pc", 32'(pc), 32'd1);
    chk("br_ones_ovf", 32'(ovf), 32'd0);
    chk("br_ones_halted", 32'(halted), 32'd0);

    // Reset beats a transfer and a branch on the same edge.
    do_reset();
    en = 1'b1; pc_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 5; i++) tick();
    pc_ready = 1'b0; br_valid = 1'b1; br_target = 2'd2;
    tick();
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    rst_n = 1'b0; pc_ready = 1'b1; br_target = 2'd3;
    tick();
    rst_n = 1'b1; br_valid = 1'b0;
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_valid", 32'(pc_valid), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    exp_q.push_back(32'd0);
    tick();
    tick();
    pc_ready = 1'b0;
    chk("post_rst_pc", 32'(pc), 32'd1);

    // en drop under back-pressure finishes one transfer then idles.
    do_reset();
    en = 1'b1; pc_ready = 1'b1;
    exp_q.push_back(32'd0);
    tick(); tick();
    pc_ready = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("en_off_valid", 32'(pc_valid), 32'd1);
      chk("en_off_pc", 32'(pc), 32'd1);
    end
    exp_q.push_back(32'd1);
    pc_ready = 1'b1;
    tick();
    chk("en_off_last_pc", 32'(pc), 32'd2);
    chk("en_off_idle_valid", 32'(pc_valid), 32'd0);
    tick();
    pc_ready = 1'b0;
    chk("idle_hold_pc", 32'(pc), 32'd2);
    chk("q_final", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
